nx_node_inbound: RTL

Receive side of the node-to-node SIGNAL path. Accepts inbound node_message_t traffic from the node's ingress router port and buffers it in a small FIFO. SIGNAL messages addressed to this node are decoded into byte-lane writes on the node's data RAM, sharing the port with the execution core, which always has priority. Malformed or misaddressed traffic is discarded and counted.

---
 rtl/nx_node_inbound_pkg.sv | 56 +++++
 rtl/nx_node_inbound_fifo.sv | 64 ++++++
 rtl/nx_node_inbound.sv | 82 ++++++++
 3 files changed

// File: rtl/nx_node_inbound_pkg.sv
// Shared node message, signal and lane types used by the node inbound path and the core.
package nx_node_inbound_pkg;

  localparam int ROW_W      = 4;
  localparam int COL_W      = 4;
  localparam int MSG_ADDR_W = 11;

  typedef enum logic [1:0] {
    NODE_COMMAND_LOAD    = 2'd0,
    NODE_COMMAND_SIGNAL  = 2'd1,
    NODE_COMMAND_CONTROL = 2'd2,
    NODE_COMMAND_TRACE   = 2'd3
  } node_command_t;

  // Selects lane[0] of a signal write relative to the core's current slot.
  typedef enum logic [1:0] {
    NODE_SIG_SLOT_PRESERVE = 2'd0,
    NODE_SIG_SLOT_INVERSE  = 2'd1,
    NODE_SIG_SLOT_LOWER    = 2'd2,
    NODE_SIG_SLOT_UPPER    = 2'd3
  } node_sig_slot_t;

  typedef logic [1:0] node_lane_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] column;
  } node_id_t;

  typedef struct packed {
    logic [MSG_ADDR_W-1:0] address;
    node_sig_slot_t        slot;
    logic [7:0]            data;
  } node_signal_t;

  typedef struct packed {
    node_id_t      target;
    node_command_t command;
    node_signal_t  payload;
  } node_message_t;

  function automatic node_lane_t sig_lane(input logic [MSG_ADDR_W-1:0] address,
                                          input node_sig_slot_t        slot,
                                          input logic                  cur_slot);
    node_lane_t lane;
    lane[1] = address[0];
    case (slot)
      NODE_SIG_SLOT_PRESERVE: lane[0] = cur_slot;
      NODE_SIG_SLOT_INVERSE:  lane[0] = ~cur_slot;
      NODE_SIG_SLOT_LOWER:    lane[0] = 1'b0;
      default:                lane[0] = 1'b1;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/nx_node_inbound_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with full/empty/level; head data is shown combinationally.
module nx_fifo_sync #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign o_full      = (level_q == (PTR_W+1)'(DEPTH));
  assign o_empty     = (level_q == '0);
  assign o_level     = level_q;
  assign o_head_data = mem_q[rd_ptr_q];
  assign do_push     = i_push && !o_full;
  assign do_pop      = i_pop && !o_empty;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; the level counter alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/nx_node_inbound.sv
// Inbound SIGNAL path: buffers router traffic and turns SIGNAL messages for this node
// into byte-lane data RAM writes, yielding to the core; everything else is dropped and counted.
module nx_node_inbound
  import nx_node_inbound_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ROW_W-1:0]      i_node_row,
  input  logic [COL_W-1:0]      i_node_col,
  input  logic                  i_slot,
  input  node_message_t         i_msg_data,
  input  logic                  i_msg_valid,
  output logic                  o_msg_ready,
  input  logic                  i_core_access,
  output logic [RAM_ADDR_W-1:0] o_data_addr,
  output logic [RAM_DATA_W-1:0] o_data_wr_data,
  output logic [RAM_DATA_W-1:0] o_data_wr_strb,
  output logic                  o_data_wr_en,
  output logic                  o_busy,
  output logic [7:0]            o_dropped
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  node_message_t    head;
  node_lane_t       lane;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             head_valid, accept, drop, pop;
  logic [7:0]       dropped_q, dropped_d;

  assign o_msg_ready = !fifo_full;
  assign o_busy      = (fifo_level != '0);
  assign o_dropped   = dropped_q;
  assign head_valid  = !fifo_empty;

  nx_fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(node_message_t))
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (i_msg_valid && o_msg_ready),
    .i_push_data (i_msg_data),
    .i_pop       (pop),
    .o_head_data (head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_level     (fifo_level)
  );

  // Lane follows i_slot live, so a stalled write tracks slot changes until it issues.
  always_comb begin
    accept = (head.command == NODE_COMMAND_SIGNAL) &&
             (head.target.row == i_node_row) &&
             (head.target.column == i_node_col);
    lane           = sig_lane(head.payload.address, head.payload.slot, i_slot);
    o_data_wr_en   = head_valid && accept && !i_core_access;
    o_data_addr    = '0;
    o_data_wr_data = '0;
    o_data_wr_strb = '0;
    if (head_valid) begin
      o_data_addr    = RAM_ADDR_W'(head.payload.address[MSG_ADDR_W-1:1]);
      o_data_wr_data = RAM_DATA_W'({4{head.payload.data}});
      o_data_wr_strb = RAM_DATA_W'(32'hFF << {lane, 3'd0});
    end
    drop = head_valid && !accept;
    pop  = o_data_wr_en || drop;
    dropped_d = dropped_q;
    if (drop && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) dropped_q <= '0;
    else       dropped_q <= dropped_d;
  end

endmodule
